// File: rtl/inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: format codes, FSM states, field bundle.
package inst_encoder_pkg;
  localparam int WORD_W = 32;

  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;
  localparam logic [2:0] IMM_R = 3'd6;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {ENC_IDLE, ENC_RUN, ENC_DRAIN} enc_state_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;
endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: builds the RV32I word and flags immediates the format cannot hold.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fields_t           f_i,
  output logic [WORD_W-1:0] inst_o,
  output logic              illegal_o
);
  logic [31:0] imm;
  assign imm = f_i.imm;

  always_comb begin
    inst_o    = ZERO_WORD;
    illegal_o = 1'b0;
    case (f_i.fmt)
      IMM_R: inst_o = {f_i.funct7, f_i.rs2, f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
      IMM_I: begin
        inst_o    = {imm[11:0], f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
        illegal_o = !(&imm[31:11] || ~|imm[31:11]);
      end
      IMM_S: begin
        inst_o    = {imm[11:5], f_i.rs2, f_i.rs1, f_i.funct3, imm[4:0], f_i.opcode};
        illegal_o = !(&imm[31:11] || ~|imm[31:11]);
      end
      IMM_B: begin
        inst_o    = {imm[12], imm[10:5], f_i.rs2, f_i.rs1, f_i.funct3, imm[4:1], imm[11], f_i.opcode};
        illegal_o = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      end
      IMM_U: begin
        inst_o    = {imm[31:12], f_i.rd, f_i.opcode};
        illegal_o = |imm[11:0];
      end
      IMM_J: begin
        inst_o    = {imm[20], imm[10:1], imm[11], imm[19:12], f_i.rd, f_i.opcode};
        illegal_o = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/inst_encoder.sv
// Burst instruction encoder: accepts field bundles and emits (address, word) writes through
// a one-entry output register, counting illegal immediates per burst.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WORD_W-1:0] inst_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  err_cnt_o
);
  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, addr_q;
  logic [CNT_W-1:0]  rem_q, err_cnt_q;
  logic [WORD_W-1:0] inst_q;
  logic              out_valid_q, err_q, zero_done_q;

  fields_t           fields;
  logic [WORD_W-1:0] packed_inst;
  logic              packed_illegal;
  logic              accept, beat_taken, start_ok;

  assign fields = '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                    funct3: funct3_i, funct7: funct7_i, imm: imm_i};

  inst_pack u_pack (.f_i(fields), .inst_o(packed_inst), .illegal_o(packed_illegal));

  assign in_ready_o = (state_q == ENC_RUN) && (rem_q != '0) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign beat_taken = out_valid_q && out_ready_i;
  assign start_ok   = (state_q == ENC_IDLE) && start_i && (len_i != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_IDLE:  if (start_ok) state_d = ENC_RUN;
      ENC_RUN:   if (accept && rem_q == CNT_W'(1)) state_d = ENC_DRAIN;
      ENC_DRAIN: if (beat_taken) state_d = ENC_IDLE;
      default:   state_d = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ENC_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr_q <= '0;
      rem_q       <= '0;
      err_cnt_q   <= '0;
      addr_q      <= '0;
      inst_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= (state_q == ENC_IDLE) && start_i && (len_i == '0);
      if (start_ok) begin
        next_addr_q <= {base_i[ADDR_W-1:2], 2'b00};
        rem_q       <= len_i;
        err_cnt_q   <= '0;
      end
      if (accept) begin
        next_addr_q <= next_addr_q + ADDR_W'(4);
        rem_q       <= rem_q - CNT_W'(1);
        if (packed_illegal && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        addr_q      <= next_addr_q;
        inst_q      <= packed_inst;
        err_q       <= packed_illegal;
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        // Beat consumed with nothing behind it: hold data, drop the qualifiers.
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign addr_o      = addr_q;
  assign inst_o      = inst_q;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;
  assign busy_o      = (state_q != ENC_IDLE);
  assign done_o      = zero_done_q || ((state_q == ENC_DRAIN) && beat_taken);
endmodule

// File: tb/tb_inst_encoder.sv
// Table-driven bench with a scoreboard queue of expected (addr, inst, err) beats.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 0, rst = 1;
  logic        start_i = 0, in_valid_i = 0, out_ready_i = 1;
  logic [31:0] base_i = 0;
  logic [15:0] len_i = 0;
  logic [2:0]  fmt_i = 0, funct3_i = 0;
  logic [6:0]  opcode_i = 0, funct7_i = 0;
  logic [4:0]  rd_i = 0, rs1_i = 0, rs2_i = 0;
  logic [31:0] imm_i = 0;
  logic        in_ready_o, out_valid_o, err_o, busy_o, done_o;
  logic [31:0] addr_o, inst_o;
  logic [15:0] err_cnt_o;

  inst_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .fmt_i(fmt_i), .opcode_i(opcode_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .imm_i(imm_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .addr_o(addr_o),
    .inst_o(inst_o), .err_o(err_o), .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fmt; logic [6:0] op; logic [4:0] rd, rs1, rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
    logic [31:0] inst; logic err;
  } vec_t;
  typedef struct { logic [31:0] addr; logic [31:0] inst; logic err; } beat_t;

  vec_t  tbl[12];
  beat_t q[$];
  int    n_vec = 0, n_bad = 0, done_cnt = 0, cyc = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_errs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted write beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) done_cnt++;
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) chk("unexpected_beat", inst_o, 32'hDEAD_BEEF);
        else begin
          beat_t b;
          b = q.pop_front();
          chk("beat_addr", addr_o, b.addr);
          chk("beat_inst", inst_o, b.inst);
          chk("beat_err", {31'd0, err_o}, {31'd0, b.err});
        end
      end
    end
  end

  task automatic start_burst(input logic [31:0] base, input logic [15:0] len);
    start_i = 1; base_i = base; len_i = len;
    @(posedge clk); #1;
    start_i = 0;
    exp_addr = {base[31:2], 2'b00};
    exp_errs = 0;
  endtask

  task automatic send(input vec_t v, output int acc_cyc);
    bit ok = 0;
    fmt_i = v.fmt; opcode_i = v.op; rd_i = v.rd; rs1_i = v.rs1; rs2_i = v.rs2;
    funct3_i = v.f3; funct7_i = v.f7; imm_i = v.imm; in_valid_i = 1;
    acc_cyc = -1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok = 1; acc_cyc = cyc;
        q.push_back('{exp_addr, v.inst, v.err});
        exp_addr = exp_addr + 32'd4;
        if (v.err && exp_errs != 16'hFFFF) exp_errs++;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int c = 0; c < 100 && !idle; c++) begin
      @(negedge clk);
      if (!busy_o) idle = 1;
    end
    chk(name, {31'd0, idle}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, d0;
    logic [31:0] hold_inst, hold_addr;
    //           fmt    op     rd rs1 rs2 f3 f7     imm           inst          err
    tbl[0]  = '{IMM_I, 7'h13, 1, 0, 0, 0, 0,     32'hFFFFFFFF, 32'hFFF00093, 0};
    tbl[1]  = '{IMM_B, 7'h63, 0, 1, 2, 0, 0,     32'hFFFFFFFC, 32'hFE208EE3, 0};
    tbl[2]  = '{IMM_B, 7'h63, 0, 1, 2, 0, 0,     32'h00000003, 32'h00208163, 1};
    tbl[3]  = '{IMM_J, 7'h6F, 1, 0, 0, 0, 0,     32'h00000800, 32'h001000EF, 0};
    tbl[4]  = '{IMM_U, 7'h37, 5, 0, 0, 0, 0,     32'h12345000, 32'h123452B7, 0};
    tbl[5]  = '{IMM_U, 7'h37, 5, 0, 0, 0, 0,     32'h12345001, 32'h123452B7, 1};
    tbl[6]  = '{IMM_R, 7'h33, 3, 1, 2, 0, 0,     32'hFFFFFFFF, 32'h002081B3, 0};
    tbl[7]  = '{IMM_R, 7'h33, 3, 1, 2, 0, 7'h20, 32'h00000000, 32'h402081B3, 0};
    tbl[8]  = '{IMM_S, 7'h23, 0, 1, 2, 2, 0,     32'h00000008, 32'h0020A423, 0};
    tbl[9]  = '{IMM_I, 7'h13, 1, 0, 0, 0, 0,     32'h00000800, 32'h80000093, 1};
    tbl[10] = '{3'd7,  7'h13, 1, 0, 0, 0, 0,     32'h00000000, 32'h00000000, 1};
    tbl[11] = '{3'd0,  7'h13, 1, 0, 0, 0, 0,     32'h00000000, 32'h00000000, 1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_err_cnt", {16'd0, err_cnt_o}, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    // Three addi back to back at full throughput
    start_burst(32'h100, 3);
    send(tbl[0], a0); send(tbl[0], a1); send(tbl[0], a2);
    chk("thru_1", a1 - a0, 1);
    chk("thru_2", a2 - a1, 1);
    wait_idle("a_idle");
    chk("a_done_cnt", done_cnt, 1);
    chk("a_err_cnt", {16'd0, err_cnt_o}, 0);

    // Whole table in one burst
    start_burst(32'h1000, 12);
    for (int i = 0; i < 12; i++) send(tbl[i], a0);
    wait_idle("tbl_idle");
    chk("tbl_done_cnt", done_cnt, 2);
    chk("tbl_err_cnt", {16'd0, err_cnt_o}, {16'd0, exp_errs});
    chk("tbl_q_empty", q.size(), 0);

    // Backpressure mid-burst
    start_burst(32'h2000, 4);
    send(tbl[1], a0); send(tbl[4], a0);
    out_ready_i = 0;
    @(negedge clk);
    hold_inst = inst_o; hold_addr = addr_o;
    in_valid_i = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_inst_stable", inst_o, hold_inst);
      chk("bp_addr_stable", addr_o, hold_addr);
      chk("bp_in_ready", {31'd0, in_ready_o}, 0);
      chk("bp_out_valid", {31'd0, out_valid_o}, 1);
    end
    @(posedge clk); #1;
    in_valid_i = 0; out_ready_i = 1;
    send(tbl[6], a0); send(tbl[8], a0);
    wait_idle("bp_idle");
    chk("bp_done_cnt", done_cnt, 3);
    chk("bp_q_empty", q.size(), 0);

    // len=0: done pulse, no beats
    d0 = done_cnt;
    start_burst(32'h3000, 0);
    repeat (3) @(negedge clk);
    chk("len0_done", done_cnt - d0, 1);
    chk("len0_busy", {31'd0, busy_o}, 0);
    @(posedge clk); #1;

    // Address wrap, with base low bits ignored
    start_burst(32'hFFFFFFFE, 2);
    send(tbl[0], a0); send(tbl[3], a0);
    wait_idle("wrap_idle");
    chk("wrap_q_empty", q.size(), 0);
    chk("wrap_done_cnt", done_cnt, 5);

    // start_i during RUN is ignored
    start_burst(32'h200, 2);
    send(tbl[0], a0);
    start_i = 1; base_i = 32'h900; len_i = 5;
    @(posedge clk); #1 start_i = 0;
    send(tbl[7], a0);
    wait_idle("srun_idle");
    chk("srun_q_empty", q.size(), 0);
    chk("srun_done_cnt", done_cnt, 6);

    // Reset mid-burst with a held illegal beat
    out_ready_i = 0;
    start_burst(32'h300, 3);
    send(tbl[5], a0);
    @(negedge clk);
    chk("pre_rst_err_cnt", {16'd0, err_cnt_o}, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_out_valid", {31'd0, out_valid_o}, 0);
    chk("mrst_busy", {31'd0, busy_o}, 0);
    chk("mrst_addr", addr_o, 0);
    chk("mrst_inst", inst_o, 0);
    chk("mrst_err_cnt", {16'd0, err_cnt_o}, 0);
    chk("mrst_in_ready", {31'd0, in_ready_o}, 0);
    q.delete();
    @(posedge clk); #1 rst = 0; out_ready_i = 1;
    @(posedge clk); #1;
    chk("mrst_no_done", done_cnt, 6);

    // Clean restart
    start_burst(32'h400, 1);
    @(negedge clk);
    chk("new_err_cnt", {16'd0, err_cnt_o}, 0);
    @(posedge clk); #1;
    send(tbl[4], a0);
    wait_idle("new_idle");
    chk("new_done_cnt", done_cnt, 7);
    chk("new_q_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the decode-side immediate generator: packs opcode, register fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Emits instructions as a stream of (address, word) writes to instruction memory; used by the self-test/debug program loader.
- A burst is started with a base address and an instruction count; an FSM tracks the burst.
- Illegal immediates (out of range or misaligned) are flagged per beat and counted.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- CNT_W, 16, width of the burst length and error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  start burst (accepted only in IDLE)
- base_i  in  ADDR_W  burst base byte address; bits [1:0] ignored, treated as 0
- len_i  in  CNT_W  number of instructions in the burst
- in_valid_i  in  1  field bundle valid
- in_ready_o  out  1  encoder can accept a bundle
- fmt_i  in  3  format select: `IMM_I/`IMM_S/`IMM_B/`IMM_U/`IMM_J, plus new `IMM_R
- opcode_i  in  7  opcode
- rd_i  in  5  rd field
- rs1_i  in  5  rs1 field
- rs2_i  in  5  rs2 field
- funct3_i  in  3  funct3 field
- funct7_i  in  7  funct7 field
- imm_i  in  32  immediate, as the decoder would reproduce it
- out_valid_o  out  1  write beat valid
- out_ready_i  in  1  memory accepts beat
- addr_o  out  ADDR_W  write byte address
- inst_o  out  `WordBus  encoded instruction
- err_o  out  1  this beat's immediate was illegal
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle pulse at burst completion
- err_cnt_o  out  CNT_W  illegal-immediate count for current burst, saturating

Behaviour:
- Reset: FSM=IDLE; out_valid_o, err_o, done_o, busy_o = 0; addr_o, inst_o, err_cnt_o = 0; in_ready_o = 0. Reset mid-burst abandons the burst: the held beat is dropped and no done_o is generated.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start_i with len_i!=0 → RUN. On entry, latch addr=base_i with bits [1:0]=0, remaining=len_i, and clear err_cnt_o.
  - IDLE: start_i with len_i==0 → done_o pulses next cycle and the FSM stays in IDLE.
  - RUN: accept bundles until remaining reaches 0, then → DRAIN.
  - DRAIN: when the last beat is accepted (out_valid_o & out_ready_i), → IDLE and pulse done_o in that cycle.
  - start_i is ignored outside IDLE.
- Handshake: single output register (one-entry pipeline).
  - in_ready_o = RUN & remaining!=0 & (!out_valid_o | out_ready_i).
  - A bundle is accepted on in_valid_i & in_ready_o. The encoded word appears on inst_o/addr_o with out_valid_o=1 the next cycle (latency 1).
  - Full throughput: 1 beat/cycle when out_ready_i is held at 1.
  - Outputs stay stable while out_valid_o & !out_ready_i.
  - addr increments by 4 per accepted bundle; wraps modulo 2^ADDR_W silently.
- Encoding, with low 7 bits = opcode_i in every format:
  - R: funct7|rs2|rs1|funct3|rd.
  - I: imm[11:0]|rs1|funct3|rd.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
  - Unknown fmt: inst=`ZeroWord, err=1.
- Legality (err on that beat when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
  - R: imm ignored, never err.
  - An illegal beat is still emitted, using the truncated fields.
- err_cnt_o increments when an illegal bundle is accepted; saturates at 2^CNT_W-1.
- Round-trip invariant: for legal inputs, the immediate generator applied to inst_o reproduces imm_i exactly.

Decomposition:
- defines.vh:
  - add `IMM_R, with a value distinct from the existing `IMM_* codes;
  - add encoder FSM state localparams (ENC_IDLE/ENC_RUN/ENC_DRAIN).
- Sub-module inst_pack: purely combinational field packer plus legality check (fmt, fields, imm → inst, illegal).
- inst_encoder holds the FSM, counters and output register.

Test Plan:
- Start base=0x100, len=3; send I addi rd=1 rs1=0 imm=-1, out_ready_i=1 → inst 0xFFF00093 @0x100, 1 beat/cycle, done_o pulses once, err_cnt_o=0.
- B beq rs1=1 rs2=2 imm=-4 → 0xFE208EE3. Then imm=3 → err_o=1 on that beat and err_cnt_o=1.
- J jal rd=1 imm=0x800 → 0x001000EF. U lui rd=5 imm=0x12345000 → 0x123452B7. U with imm=0x12345001 → err_o=1.
- Backpressure: hold out_ready_i=0 for 5 cycles mid-burst → inst_o/addr_o stable, in_ready_o=0, no beats lost or duplicated.
- Boundaries:
  - len=0 → done_o pulse, no beats.
  - base=0xFFFFFFFC, len=2 → addresses 0xFFFFFFFC then 0x0.
  - start_i asserted during RUN → ignored.
- Reset asserted mid-burst → all outputs return to reset values next cycle; a new start then begins cleanly with err_cnt_o=0.
